modbus_tx_framer: RTL
=====================

# modbus_tx_framer

Response-side companion of the Modbus RTU function handler. On each `handler_done` pulse it builds the RTU response frame (normal or exception) from the handler's latched fields and the response DPRAM, appends CRC-16/Modbus, and streams bytes to the UART transmitter over a valid/ready byte handshake. It also enforces the t3.5 inter-frame silence before the next frame may start.

## Interface
- `GAP_CYCLES`, default 401042: idle clocks enforced after the last CRC byte (3.5 chars at 9600 baud, 100 MHz).
- `MAX_WORDS`, default 125: largest accepted `tx_quantity` for 03/04.
- `clk`, in, 1: system clock, single clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `dev_addr`, in, 8: slave address placed in byte 0.
- `handler_done`, in, 1: one-cycle start pulse.
- `func_code_r`, in, 8: function code (03/04/06).
- `addr_r`, in, 16: register address (06 echo).
- `data_r`, in, 16: register value (06 echo).
- `tx_quantity`, in, 8: word count N for 03/04.
- `exception_out`, in, 8: nonzero selects an exception frame.
- `dpram_raddr`, out, 8: DPRAM read address.
- `dpram_rdata`, in, 16: DPRAM data, one-cycle read latency.
- `tx_data`, out, 8: byte to UART.
- `tx_valid`, out, 1: byte available.
- `tx_ready`, in, 1: UART accepts; a transfer occurs when valid and ready are both high.
- `tx_busy`, out, 1: high from frame start through the end of the gap.
- `tx_frame_done`, out, 1: one-cycle pulse after the CRC high byte transfers, or on an aborted frame.
- `frame_err`, out, 1: qualifies `tx_frame_done` and marks an aborted frame.

## Operation
- Field capture: at `handler_done`, all inputs (dev_addr … exception_out) are copied into a one-deep request register.
  - If the framer is idle, the request starts immediately.
  - If the framer is busy or in the gap, the request is held pending and starts when the gap ends.
  - A further `handler_done` while a request is already pending is dropped.
- Frame formats (CRC bytes are sent low byte first):
  - Exception (`exception_out != 0`): dev_addr, func|0x80, exception_out, CRC. 5 bytes.
  - 03/04: dev_addr, func, 2N, then N words taken from `dpram[0..N-1]` (high byte then low byte), then CRC. 5+2N bytes.
  - 06: dev_addr, 06, addr_r hi, addr_r lo, data_r hi, data_r lo, CRC. 8 bytes.
  - Abort: any other func, or N=0 or N>MAX_WORDS on 03/04 with no exception. No bytes are sent, `tx_frame_done` and `frame_err` pulse, and the gap is still applied.
- CRC: init 0xFFFF, reflected polynomial 0xA001, one byte per cycle (8 unrolled shifts). The CRC updates on each transfer of a non-CRC byte and reinitialises at frame start.
- FSM states and transitions:
  - IDLE → HDR_ADDR → HDR_FUNC → BODY.
  - BODY holds the exception code, the byte count, or the 06 echo bytes.
  - 03/04 data loop: RD_ISSUE → DATA_HI → DATA_LO, repeated N times.
  - Frame end: CRC_LO → CRC_HI → GAP → IDLE.
- Word counter: 8-bit. `dpram_raddr` equals the word index; it never wraps because N ≤ MAX_WORDS.
- Byte count field: 2N is computed in 9 bits and sent as its low 8 bits (exact for N ≤ 127).

## Timing
- Reset values: tx_valid=0, tx_data=0x00, dpram_raddr=0x00, tx_busy=0, tx_frame_done=0, frame_err=0, CRC=0xFFFF, FSM=IDLE, pending cleared.
- Start latency: `handler_done` in cycle 0 → `tx_valid`=1 with dev_addr in cycle 1. `tx_busy` rises in cycle 1.
- Byte handshake: `tx_data` is held stable while valid && !ready. The next byte is presented in the cycle after the transfer.
- Throughput with `tx_ready` held high:
  - One byte per cycle, except exactly one bubble cycle before each DATA_HI byte (DPRAM read latency).
  - Aborted frames go straight from IDLE to GAP.
- Frame end: `tx_frame_done` pulses in the cycle after the CRC_HI transfer. GAP then counts GAP_CYCLES clocks, and `tx_busy` falls at the end of the count.
- Pending start: a pending request starts in the cycle `tx_busy` falls, with `tx_valid` high in the same cycle.
- Reset mid-frame (rst_n low at any point): outputs return to reset values asynchronously, and the partial frame plus any pending request are discarded.

## Structure
- Package `modbus_pkg`:
  - function-code constants FC_READ_HOLD=0x03, FC_READ_INPUT=0x04, FC_WRITE_SINGLE=0x06;
  - EXC_FLAG=0x80;
  - CRC_INIT=0xFFFF, CRC_POLY=0xA001;
  - FSM state enum.
- Sub-module `modbus_crc16_byte`: combinational CRC update, (crc_in[15:0], byte[7:0]) → crc_out. It is shared with the receiver's CRC checker.

## Test plan
- Exception: dev=0x01, func=0x04, exc=0x02 → bytes 01 84 02 C2 C1, then `tx_frame_done` pulses with `frame_err`=0.
- Write echo: dev=0x01, func=0x06, addr=0x0001, data=0x0003 → bytes 01 06 00 01 00 03 98 0B.
- Read with backpressure: func=0x04, N=3, dpram={0x1111,0x2222,0x3333}, tx_ready random at 50% → 01 04 06 11 11 22 22 33 33 + golden CRC; tx_data stable while stalled.
- Back-to-back requests: second `handler_done` during frame 1 → frame 2 starts exactly GAP_CYCLES clocks after frame 1's `tx_frame_done`; a third pulse while pending is dropped.
- Abort: func=0x03, N=0, exc=0 → no `tx_valid`, `tx_frame_done` and `frame_err` pulse together, `tx_busy` high for the gap.
- Reset mid-DATA_LO → all outputs at reset values immediately; a fresh 06 request afterwards produces a correct 8-byte frame.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared constants and types for the Modbus RTU response path.
// Function codes, CRC parameters, framer state and request bundle.
package modbus_pkg;

  localparam logic [7:0] FC_READ_HOLD    = 8'h03;
  localparam logic [7:0] FC_READ_INPUT   = 8'h04;
  localparam logic [7:0] FC_WRITE_SINGLE = 8'h06;
  localparam logic [7:0] EXC_FLAG        = 8'h80;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR_ADDR,
    ST_HDR_FUNC,
    ST_BODY,
    ST_RD_ISSUE,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_GAP
  } tx_state_e;

  typedef struct packed {
    logic [7:0]  dev;
    logic [7:0]  func;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  qty;
    logic [7:0]  exc;
  } req_t;

  function automatic logic is_read_fc(logic [7:0] f);
    return (f == FC_READ_HOLD) || (f == FC_READ_INPUT);
  endfunction

  // A request that yields no bytes: unknown function or bad word count.
  function automatic logic req_abort(req_t r, logic [8:0] max_w);
    logic rd_ok;
    logic wr_ok;
    rd_ok = is_read_fc(r.func) && (r.qty != 8'd0) &&
            ({1'b0, r.qty} <= max_w);
    wr_ok = (r.func == FC_WRITE_SINGLE);
    return (r.exc == 8'd0) && !rd_ok && !wr_ok;
  endfunction

endpackage

// File: rtl/modbus_crc16_byte.sv
// CRC-16/Modbus update of one byte, fully unrolled.
// Shared by the transmit framer and the receive checker.
module modbus_crc16_byte
  import modbus_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  // Eight reflected shift/xor steps per byte.
  always_comb begin
    c = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/modbus_tx_framer.sv
// Modbus RTU response framer: builds the frame, appends CRC,
// streams bytes over valid/ready and enforces the t3.5 gap.
module modbus_tx_framer
  import modbus_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 401042,
  parameter int unsigned MAX_WORDS  = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  dev_addr,
  input  logic        handler_done,
  input  logic [7:0]  func_code_r,
  input  logic [15:0] addr_r,
  input  logic [15:0] data_r,
  input  logic [7:0]  tx_quantity,
  input  logic [7:0]  exception_out,
  output logic [7:0]  dpram_raddr,
  input  logic [15:0] dpram_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_frame_done,
  output logic        frame_err
);

  localparam int unsigned GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [8:0]    MAXW     = 9'(MAX_WORDS);

  tx_state_e   state_q, state_d;
  req_t        cur_q, cur_d;
  req_t        pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  word_q, word_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  lo_q, lo_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  req_t        in_req;
  req_t        src;
  logic        xfer;
  logic        gap_end;
  logic        start;
  logic        cur_exc;
  logic        cur_wr;
  logic [8:0]  qty_x2;
  logic [15:0] crc_next;

  assign in_req = {dev_addr, func_code_r, addr_r, data_r,
                   tx_quantity, exception_out};
  assign src     = pend_vld_q ? pend_q : in_req;
  assign xfer    = tx_valid && tx_ready;
  assign gap_end = (state_q == ST_GAP) && (gap_q == GAP_LAST);
  assign start   = ((state_q == ST_IDLE) || gap_end) &&
                   (pend_vld_q || handler_done);
  assign cur_exc = (cur_q.exc != 8'd0);
  assign cur_wr  = (cur_q.func == FC_WRITE_SINGLE);
  assign qty_x2  = {cur_q.qty, 1'b0};

  assign dpram_raddr   = word_q;
  assign tx_busy       = (state_q != ST_IDLE);
  assign tx_frame_done = done_q;
  assign frame_err     = err_q;

  modbus_crc16_byte u_crc (
    .crc_in  (crc_q),
    .data_in (tx_data),
    .crc_out (crc_next)
  );

  // Byte presented to the UART, decoded from the current state.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      ST_HDR_ADDR: begin
        tx_valid = 1'b1;
        tx_data  = cur_q.dev;
      end
      ST_HDR_FUNC: begin
        tx_valid = 1'b1;
        tx_data  = cur_exc ? (cur_q.func | EXC_FLAG) : cur_q.func;
      end
      ST_BODY: begin
        tx_valid = 1'b1;
        if (cur_exc) begin
          tx_data = cur_q.exc;
        end else if (cur_wr) begin
          case (bidx_q)
            2'd0:    tx_data = cur_q.addr[15:8];
            2'd1:    tx_data = cur_q.addr[7:0];
            2'd2:    tx_data = cur_q.data[15:8];
            default: tx_data = cur_q.data[7:0];
          endcase
        end else begin
          tx_data = qty_x2[7:0];
        end
      end
      ST_DATA_HI: begin
        tx_valid = 1'b1;
        tx_data  = dpram_rdata[15:8];
      end
      ST_DATA_LO: begin
        tx_valid = 1'b1;
        tx_data  = lo_q;
      end
      ST_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = crc_q[7:0];
      end
      ST_CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = crc_q[15:8];
      end
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  // Next-state, counters, CRC and request bookkeeping.
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    word_d     = word_q;
    bidx_d     = bidx_q;
    gap_d      = '0;
    crc_d      = crc_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_HDR_ADDR: if (xfer) state_d = ST_HDR_FUNC;
      ST_HDR_FUNC: if (xfer) state_d = ST_BODY;
      ST_BODY: begin
        if (xfer) begin
          if (cur_exc) begin
            state_d = ST_CRC_LO;
          end else if (cur_wr) begin
            bidx_d = bidx_q + 2'd1;
            if (bidx_q == 2'd3) state_d = ST_CRC_LO;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_DATA_HI;
      ST_DATA_HI: begin
        lo_d = dpram_rdata[7:0];
        if (xfer) state_d = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        if (xfer) begin
          word_d = word_q + 8'd1;
          if ((word_q + 8'd1) == cur_q.qty) state_d = ST_CRC_LO;
          else state_d = ST_RD_ISSUE;
        end
      end
      ST_CRC_LO: if (xfer) state_d = ST_CRC_HI;
      ST_CRC_HI: begin
        if (xfer) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_end) state_d = ST_IDLE;
      end
      default: state_d = state_q;
    endcase

    if (xfer && (state_q != ST_CRC_LO) && (state_q != ST_CRC_HI)) begin
      crc_d = crc_next;
    end

    if (start) begin
      cur_d  = src;
      word_d = 8'd0;
      bidx_d = 2'd0;
      gap_d  = '0;
      crc_d  = CRC_INIT;
      if (req_abort(src, MAXW)) begin
        state_d = ST_GAP;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end else begin
        state_d = ST_HDR_ADDR;
      end
    end

    if (start) begin
      pend_vld_d = 1'b0;
    end else if (handler_done && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_d     = in_req;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      word_q     <= 8'd0;
      bidx_q     <= 2'd0;
      gap_q      <= '0;
      crc_q      <= CRC_INIT;
      lo_q       <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      word_q     <= word_d;
      bidx_q     <= bidx_d;
      gap_q      <= gap_d;
      crc_q      <= crc_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
